// File: rtl/ph_sched_if.sv
// Bus bundle for ph_sched: eight phase-ring sample inputs, the event output
// stream and the fx register bus.
interface ph_sched_if #(
    parameter int DW = 16
);
    logic [DW-1:0] ph1_ring, ph2_ring, ph3_ring, ph4_ring;
    logic [DW-1:0] ph5_ring, ph6_ring, ph7_ring, ph8_ring;
    logic          ph1_vld, ph2_vld, ph3_vld, ph4_vld;
    logic          ph5_vld, ph6_vld, ph7_vld, ph8_vld;

    // Event stream: a transfer happens in every cycle where ev_vld && ev_rdy;
    // while ev_vld is high and ev_rdy low, ev_data/ev_ch stay stable.
    logic [DW-1:0] ev_data;
    logic [2:0]    ev_ch;
    logic          ev_vld;
    logic          ev_rdy;

    logic [21:0]   fx_waddr;
    logic          fx_wr;
    logic [7:0]    fx_data;
    logic [21:0]   fx_raddr;
    logic          fx_rd;
    logic [7:0]    fx_q;

    modport master (
        output ph1_ring, ph2_ring, ph3_ring, ph4_ring,
        output ph5_ring, ph6_ring, ph7_ring, ph8_ring,
        output ph1_vld, ph2_vld, ph3_vld, ph4_vld,
        output ph5_vld, ph6_vld, ph7_vld, ph8_vld,
        output ev_rdy, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd,
        input  ev_data, ev_ch, ev_vld, fx_q
    );

    modport slave (
        input  ph1_ring, ph2_ring, ph3_ring, ph4_ring,
        input  ph5_ring, ph6_ring, ph7_ring, ph8_ring,
        input  ph1_vld, ph2_vld, ph3_vld, ph4_vld,
        input  ph5_vld, ph6_vld, ph7_vld, ph8_vld,
        input  ev_rdy, fx_waddr, fx_wr, fx_data, fx_raddr, fx_rd,
        output ev_data, ev_ch, ev_vld, fx_q
    );
endinterface

// File: rtl/ph_sched.sv
// Eight-channel phase sample scheduler: one holding slot per channel, round-robin
// grant into a single-entry output stage, plus an fx register bank with drop counters.
module ph_sched #(
    parameter int DW = 16
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [5:0]  dev_id,
    ph_sched_if.slave   bus,
    output logic        dbg_state
);
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

    state_e        r_state, w_state_nxt;
    logic [7:0]    r_en, r_pend, r_fx_q;
    logic [DW-1:0] r_hold [8];
    logic [7:0]    r_drop [8];
    logic [2:0]    r_ptr, r_ev_ch;
    logic [DW-1:0] r_ev_data;

    logic [DW-1:0] w_ring [8];
    logic [7:0]    w_vld, w_gnt_oh, w_cap, w_drop, w_pend_nxt, w_rd_val;
    logic          w_whit, w_rhit, w_flush, w_dclr, w_en_wr;
    logic          w_gnt_found, w_grant;
    logic [2:0]    w_gnt_ch, w_idx;
    logic          w_unused_addr;

    assign w_ring[0] = bus.ph1_ring;
    assign w_ring[1] = bus.ph2_ring;
    assign w_ring[2] = bus.ph3_ring;
    assign w_ring[3] = bus.ph4_ring;
    assign w_ring[4] = bus.ph5_ring;
    assign w_ring[5] = bus.ph6_ring;
    assign w_ring[6] = bus.ph7_ring;
    assign w_ring[7] = bus.ph8_ring;
    assign w_vld = {bus.ph8_vld, bus.ph7_vld, bus.ph6_vld, bus.ph5_vld,
                    bus.ph4_vld, bus.ph3_vld, bus.ph2_vld, bus.ph1_vld};

    assign w_whit  = bus.fx_wr && (bus.fx_waddr[21:16] == dev_id);
    assign w_rhit  = bus.fx_rd && (bus.fx_raddr[21:16] == dev_id);
    assign w_flush = w_whit && (bus.fx_waddr[7:0] == 8'h02) && bus.fx_data[0];
    assign w_dclr  = w_whit && (bus.fx_waddr[7:0] == 8'h03);
    assign w_en_wr = w_whit && (bus.fx_waddr[7:0] == 8'h00);
    assign w_unused_addr = &{1'b0, bus.fx_waddr[15:8], bus.fx_raddr[15:8]};

    // Round-robin search: the pointer itself is visited last (i = 8 wraps to +0).
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_ch    = r_ptr;
        w_idx       = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_gnt_found && r_pend[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_ch    = w_idx;
            end
        end
    end

    assign w_grant  = w_gnt_found && !w_flush && ((r_state == S_EMPTY) || bus.ev_rdy);
    assign w_gnt_oh = w_grant ? (8'b1 << w_gnt_ch) : 8'h00;

    // A channel being granted this cycle frees its slot, so a coincident sample lands.
    assign w_cap      = w_vld & r_en & (~r_pend | w_gnt_oh) & {8{~w_flush}};
    assign w_drop     = w_vld & r_en & r_pend & ~w_gnt_oh & {8{~w_flush}};
    assign w_pend_nxt = w_flush ? 8'h00 : ((r_pend & ~w_gnt_oh) | w_cap);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (!w_flush && (|r_pend)) w_state_nxt = S_FULL;
            S_FULL: begin
                if (w_flush)                         w_state_nxt = S_EMPTY;
                else if (bus.ev_rdy && !(|r_pend))   w_state_nxt = S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        w_rd_val = 8'h00;
        if (bus.fx_raddr[7:0] == 8'h00)             w_rd_val = r_en;
        else if (bus.fx_raddr[7:0] == 8'h01)        w_rd_val = r_pend;
        else if (bus.fx_raddr[7:3] == 5'b00010)     w_rd_val = r_drop[bus.fx_raddr[2:0]];
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            r_pend    <= 8'h00;
            r_en      <= 8'hFF;
            r_ptr     <= 3'd7;
            r_ev_data <= '0;
            r_ev_ch   <= 3'd0;
            r_fx_q    <= 8'h00;
            for (int n = 0; n < 8; n++) begin
                r_hold[n] <= '0;
                r_drop[n] <= 8'h00;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_fx_q  <= w_rhit ? w_rd_val : 8'h00;
            if (w_en_wr) r_en <= bus.fx_data;
            if (w_grant) begin
                r_ptr     <= w_gnt_ch;
                r_ev_data <= r_hold[w_gnt_ch];
                r_ev_ch   <= w_gnt_ch;
            end
            for (int n = 0; n < 8; n++) begin
                if (w_cap[n]) r_hold[n] <= w_ring[n];
                if (w_dclr)
                    r_drop[n] <= 8'h00;
                else if (w_drop[n] && (r_drop[n] != 8'hFF))
                    r_drop[n] <= r_drop[n] + 8'd1;
            end
        end
    end

    assign bus.ev_data = r_ev_data;
    assign bus.ev_ch   = r_ev_ch;
    assign bus.ev_vld  = (r_state == S_FULL);
    assign bus.fx_q    = r_fx_q;
    assign dbg_state   = r_state;
endmodule
